// File: rtl/arith_pkg.sv
// Shared arithmetic-unit definitions.
//   state_t    : sequencer states of the multi-cycle divider
//   DEFAULT_W  : default operand width of the arithmetic unit
//   cnt_width  : width of a counter that indexes n steps
package arith_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CHECK  = 2'd1,
    CALC   = 2'd2,
    FINISH = 2'd3
  } state_t;

  localparam int DEFAULT_W = 32;

  // Bits needed to count 0..n-1; at least one bit so the counter is never empty.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/signed_seq_divider_if.sv
// Start/busy/done handshake bundle for the signed sequential divider.
//   master : drives start, dividend (2N), divisor (N); observes results
//   slave  : the divider; drives busy, done, quotient, remainder,
//            div_by_zero, overflow
interface signed_seq_divider_if #(
  parameter int N = arith_pkg::DEFAULT_W
);
  logic                  start;
  logic signed [2*N-1:0] dividend;
  logic signed [N-1:0]   divisor;
  logic                  busy;
  logic                  done;
  logic signed [N-1:0]   quotient;
  logic signed [N-1:0]   remainder;
  logic                  div_by_zero;
  logic                  overflow;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero, overflow
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero, overflow
  );
endinterface

// File: rtl/restoring_div_step.sv
// One combinational step of radix-2 restoring division on magnitudes.
//   r      : partial remainder (always < dsr on entry)
//   in_bit : next dividend bit shifted in
//   dsr    : divisor magnitude
//   r_next : partial remainder after the step
//   q_bit  : quotient bit produced by the step
module restoring_div_step
  import arith_pkg::*;
#(
  parameter int N = DEFAULT_W
) (
  input  logic [N-1:0] r,
  input  logic         in_bit,
  input  logic [N-1:0] dsr,
  output logic [N-1:0] r_next,
  output logic         q_bit
);

  // Trial value needs N+1 bits: r < dsr guarantees the difference fits in N.
  logic [N:0] trial;

  assign trial  = {r, in_bit};
  assign q_bit  = (trial >= {1'b0, dsr});
  assign r_next = q_bit ? N'(trial - {1'b0, dsr}) : trial[N-1:0];

endmodule

// File: rtl/signed_seq_divider.sv
// Multi-cycle signed divider: 2N-bit dividend / N-bit divisor -> N-bit
// quotient (truncated toward zero) and N-bit remainder (sign of dividend).
// Radix-2 restoring division on magnitudes, one quotient bit per cycle.
//   clk, reset (sync, active-high), enable (clock enable for all state)
//   bus (slave): start/dividend/divisor in; busy/done/quotient/remainder/
//                div_by_zero/overflow out
// Latency from accepted start: N+2 edges normally, 2 edges when CHECK
// detects divide-by-zero or an obviously oversized quotient.
module signed_seq_divider
  import arith_pkg::*;
#(
  parameter int N = DEFAULT_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  signed_seq_divider_if.slave   bus
);

  localparam int CW = cnt_width(N);

  state_t        state;
  logic [CW-1:0] count;
  logic          err_dz;
  logic          err_ov;

  logic          sign_q;
  logic          sign_r;
  logic [N-1:0]  dsr_mag;
  // rem_mag holds the partial remainder; lo_mag starts as the low half of
  // |dividend| and fills with quotient bits from the right as it shifts out.
  logic [N-1:0]  rem_mag;
  logic [N-1:0]  lo_mag;

  logic [N-1:0]  step_r;
  logic          step_q;

  function automatic logic [2*N-1:0] mag_2n(input logic signed [2*N-1:0] v);
    logic [2*N-1:0] u;
    u = v;
    return v[2*N-1] ? (~u + 1'b1) : u;
  endfunction

  function automatic logic [N-1:0] mag_n(input logic signed [N-1:0] v);
    logic [N-1:0] u;
    u = v;
    return v[N-1] ? (~u + 1'b1) : u;
  endfunction

  function automatic logic [N-1:0] apply_sign(input logic neg, input logic [N-1:0] m);
    return neg ? (~m + 1'b1) : m;
  endfunction

  // Magnitude 2^(N-1) is representable only as a negative result.
  function automatic logic q_out_of_range(input logic neg, input logic [N-1:0] m);
    return neg ? (m[N-1] & (|m[N-2:0])) : m[N-1];
  endfunction

  restoring_div_step #(.N(N)) u_step (
    .r      (rem_mag),
    .in_bit (lo_mag[N-1]),
    .dsr    (dsr_mag),
    .r_next (step_r),
    .q_bit  (step_q)
  );

  assign bus.busy = (state != IDLE);

  // Control and result registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      count           <= '0;
      err_dz          <= 1'b0;
      err_ov          <= 1'b0;
      bus.done        <= 1'b0;
      bus.quotient    <= '0;
      bus.remainder   <= '0;
      bus.div_by_zero <= 1'b0;
      bus.overflow    <= 1'b0;
    end else if (enable) begin
      bus.done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            err_dz          <= 1'b0;
            err_ov          <= 1'b0;
            bus.div_by_zero <= 1'b0;
            bus.overflow    <= 1'b0;
            state           <= CHECK;
          end
        end
        CHECK: begin
          if (dsr_mag == '0) begin
            err_dz <= 1'b1;
            state  <= FINISH;
          end else if (rem_mag >= dsr_mag) begin
            // Upper half already >= divisor: quotient needs more than N bits.
            err_ov <= 1'b1;
            state  <= FINISH;
          end else begin
            count <= '0;
            state <= CALC;
          end
        end
        CALC: begin
          count <= count + 1'b1;
          if (count == CW'(N - 1)) state <= FINISH;
        end
        FINISH: begin
          bus.done <= 1'b1;
          state    <= IDLE;
          if (err_dz) begin
            bus.div_by_zero <= 1'b1;
            bus.quotient    <= '0;
            bus.remainder   <= '0;
          end else if (err_ov || q_out_of_range(sign_q, lo_mag)) begin
            bus.overflow  <= 1'b1;
            bus.quotient  <= '0;
            bus.remainder <= '0;
          end else begin
            bus.quotient  <= apply_sign(sign_q, lo_mag);
            bus.remainder <= apply_sign(sign_r, rem_mag);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Operand capture and iteration datapath
  always_ff @(posedge clk) begin
    if (enable) begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            sign_q            <= bus.dividend[2*N-1] ^ bus.divisor[N-1];
            sign_r            <= bus.dividend[2*N-1];
            {rem_mag, lo_mag} <= mag_2n(bus.dividend);
            dsr_mag           <= mag_n(bus.divisor);
          end
        end
        CALC: begin
          rem_mag <= step_r;
          lo_mag  <= {lo_mag[N-2:0], step_q};
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/signed_seq_divider.md
Name: signed_seq_divider

Overview:
- Multi-cycle signed divider; the inverse of the datapath's 32x32 signed tree multiplier.
- Divides a 2N-bit signed dividend, such as a multiplier product, by an N-bit signed divisor.
- Outputs an N-bit quotient and an N-bit remainder, using radix-2 restoring division on operand magnitudes.
- Sits beside the registered multiplier in the arithmetic unit, behind a start/busy/done handshake, with the same clk/reset/enable style.

Parameters:
- N, 32, operand width: divisor, quotient and remainder are N bits; the dividend is 2N bits.

Ports:
- clk  in  1  clock; one clock domain, all state on posedge.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  clock enable; when 0, all state and outputs hold, and start is ignored.
- start  in  1  request; sampled only when enable=1 and the block is in IDLE.
- dividend  in  2N  signed dividend, two's complement.
- divisor  in  N  signed divisor, two's complement.
- busy  out  1  high in every state other than IDLE.
- done  out  1  one-cycle pulse when results are valid.
- quotient  out  N  signed quotient, truncated toward zero.
- remainder  out  N  signed remainder; sign follows the dividend.
- div_by_zero  out  1  divisor was 0.
- overflow  out  1  quotient is not representable in N signed bits.

Behaviour:
- Reset: state=IDLE; busy, done, quotient, remainder, div_by_zero and overflow are all 0. Reset takes priority over enable.
- Reset mid-operation aborts the division. busy=0 after that edge; any partial result is discarded.
- States:
  - IDLE: start=1 captures sign_q = dividend[2N-1]^divisor[N-1] and sign_r = dividend[2N-1]. It also captures |dividend| (2N-bit unsigned) and |divisor| (N-bit unsigned), then goes to CHECK.
  - CHECK:
    - If |divisor|==0: set div_by_zero and go to FINISH.
    - Else if |dividend|[2N-1:N] >= |divisor| (unsigned quotient >= 2^N): set overflow and go to FINISH.
    - Else go to CALC with count=0, and the partial remainder R = the upper N bits of |dividend|.
  - CALC: runs N cycles, one step per cycle.
    - Shift {R, next dividend bit} left; the trial value T is N+1 bits.
    - If T >= |divisor|: R=T-|divisor| and the quotient bit is 1.
    - Else: R=T[N-1:0] and the quotient bit is 0.
    - On count==N-1, go to FINISH.
  - FINISH:
    - Apply signs: Q = sign_q ? -Qmag : Qmag; Rem = sign_r ? -R : R.
    - Range check: overflow is also set if Qmag > 2^(N-1)-1 with sign_q=0, or Qmag > 2^(N-1) with sign_q=1.
    - Register outputs, pulse done=1, and return to IDLE.
- Any error (div_by_zero or overflow): quotient=0 and remainder=0. The flags are cleared at the next accepted start.
- done is high exactly one cycle.
- quotient, remainder and the flags hold until the next accepted start or reset.
- Latency, with start accepted at edge k:
  - Normal: done visible after edge k+N+2 (34 cycles for N=32).
  - Error found in CHECK: done visible after edge k+2.
- start while busy=1 is ignored; no queueing.
- start while done=1 is legal: the block is already in IDLE and accepts it.
- enable=0 mid-operation freezes the state, counter and partial remainder. Latency extends by the number of stalled cycles.
- Most-negative dividend: its magnitude 2^(2N-1) fits in 2N-bit unsigned; no special case is needed.
- The counter width is clog2(N).

Decomposition:
- Shared package arith_pkg:
  - state encoding IDLE/CHECK/CALC/FINISH;
  - default width constant 32;
  - the counter width function.
- Sub-module restoring_div_step: combinational single step.
  - Inputs: R (N bits), incoming bit, |divisor|.
  - Outputs: next R and quotient bit.
  - Instantiated once inside the CALC datapath.

Test Plan:
- dividend=100, divisor=7, start pulse -> busy for 34 cycles; done=1 with quotient=14, remainder=2, flags 0.
- dividend=-100, divisor=7 -> quotient=-14 (0xFFFFFFF2), remainder=-2 (0xFFFFFFFE); also 100/-7 -> quotient=-14, remainder=2.
- dividend=0x3FFFFFFF00000001 (0x7FFFFFFF squared), divisor=0x7FFFFFFF -> quotient=0x7FFFFFFF, remainder=0. Also randomized: product of two random 32-bit operands divided by one of them -> the other operand, remainder 0.
- divisor=0, dividend=55 -> done 2 cycles after start; div_by_zero=1, quotient=0, remainder=0. The next valid start clears the flag.
- Overflow cases:
  - dividend=0xFFFFFFFF80000000, divisor=-1 -> overflow=1, quotient=0.
  - same dividend, divisor=1 -> quotient=0x80000000, overflow=0.
  - dividend=2^40, divisor=2 -> overflow=1 from CHECK, done 2 cycles after start.
- Control cases:
  - start re-asserted during CALC -> ignored; the result matches the first operands.
  - reset at CALC count=10 -> next cycle busy=0, done=0, outputs 0.
  - enable=0 for 5 cycles mid-CALC -> done at 39 cycles with the correct result.
